rfid_frame_rx: RTL and testbench

- Serial front end that receives ASCII tag frames from the 125 kHz RFID reader module over a UART line (8N1) and decodes each frame into a 40-bit tag ID.
- Issues a single-cycle valid or error strobe per frame.
- Sits between the reader's TX pin and the door access state machine, which consumes tag_id/tag_valid in place of the manual credential switches and verify button.

---
 rtl/rfid_pkg.sv | 35 +++
 rtl/rfid_frame_rx_uart.sv | 84 ++++++++
 rtl/rfid_frame_rx.sv | 152 +++++++++++++++
 tb/tb_rfid_frame_rx.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfid_pkg.sv
// Shared constants, state encodings and helpers for the RFID frame receiver.
package rfid_pkg;

  localparam logic [7:0] STX = 8'h02;
  localparam logic [7:0] ETX = 8'h03;
  localparam int DATA_CHARS = 10;
  localparam int CSUM_CHARS = 2;

  typedef enum logic [1:0] {
    WAIT_STX,
    DATA,
    CSUM,
    WAIT_ETX
  } parse_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_e;

  // Returns {valid, nibble}; only uppercase hex is accepted.
  function automatic logic [4:0] hex2nib(input logic [7:0] c);
    logic [4:0] r;
    r = 5'h00;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

endpackage

// File: rtl/rfid_frame_rx_uart.sv
// 8N1 byte receiver: samples at bit centres, flags bad stop bits.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_done,
  output logic [7:0] data,
  output logic       frame_err
);
  import rfid_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  rx_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     sh_q, sh_d;
  logic           prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      prev_q  <= rx;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    byte_done = 1'b0;
    frame_err = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !rx) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx ? RX_IDLE : RX_BITS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_BITS: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          sh_d  = {rx, sh_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d     = '0;
          state_d   = RX_IDLE;
          byte_done = rx;
          frame_err = !rx;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  assign data = sh_q;

endmodule

// File: rtl/rfid_frame_rx.sv
// RFID ASCII frame parser: STX, 10 hex chars, 2 checksum chars, ETX.
module rfid_frame_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [39:0] tag_id,
  output logic        tag_valid,
  output logic        tag_err,
  output logic        busy
);
  import rfid_pkg::*;

  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO_LIMIT + 1);

  logic          rx_s1_q, rx_s2_q;
  logic          byte_done, frame_err;
  logic [7:0]    rx_byte;
  parse_state_e  state_q, state_d;
  logic [39:0]   sh_q, sh_d;
  logic [7:0]    cs_q, cs_d;
  logic [3:0]    nib_q, nib_d;
  logic [TW-1:0] to_q, to_d;
  logic [39:0]   tag_id_q, tag_id_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [4:0]    hx;
  logic [7:0]    xsum;
  logic          timeout;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx_s2_q),
    .byte_done (byte_done),
    .data      (rx_byte),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      state_q  <= WAIT_STX;
      sh_q     <= '0;
      cs_q     <= '0;
      nib_q    <= '0;
      to_q     <= '0;
      tag_id_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rx_s1_q  <= rx;
      rx_s2_q  <= rx_s1_q;
      state_q  <= state_d;
      sh_q     <= sh_d;
      cs_q     <= cs_d;
      nib_q    <= nib_d;
      to_q     <= to_d;
      tag_id_q <= tag_id_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    hx   = hex2nib(rx_byte);
    xsum = sh_q[39:32] ^ sh_q[31:24] ^ sh_q[23:16] ^ sh_q[15:8] ^ sh_q[7:0];
    timeout = (state_q != WAIT_STX) && rx_s2_q && (to_q == TW'(TO_LIMIT - 1));

    state_d  = state_q;
    sh_d     = sh_q;
    cs_d     = cs_q;
    nib_d    = nib_q;
    tag_id_d = tag_id_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    // Counts cycles since the last byte; a low line means a byte is arriving.
    if (byte_done) to_d = TW'(1);
    else if (state_q == WAIT_STX || !rx_s2_q) to_d = '0;
    else to_d = to_q + TW'(1);

    if (frame_err) begin
      if (state_q != WAIT_STX) begin
        err_d   = 1'b1;
        state_d = WAIT_STX;
      end
    end else if (byte_done) begin
      if (rx_byte == STX) begin
        err_d   = (state_q != WAIT_STX);
        state_d = DATA;
        nib_d   = '0;
        sh_d    = '0;
        cs_d    = '0;
      end else begin
        unique case (state_q)
          WAIT_STX: ;
          DATA: begin
            if (!hx[4]) begin
              err_d   = 1'b1;
              state_d = WAIT_STX;
            end else begin
              sh_d = {sh_q[35:0], hx[3:0]};
              if (nib_q == 4'(DATA_CHARS - 1)) begin
                nib_d   = '0;
                state_d = CSUM;
              end else begin
                nib_d = nib_q + 4'd1;
              end
            end
          end
          CSUM: begin
            if (!hx[4]) begin
              err_d   = 1'b1;
              state_d = WAIT_STX;
            end else begin
              cs_d = {cs_q[3:0], hx[3:0]};
              if (nib_q == 4'(CSUM_CHARS - 1)) begin
                nib_d   = '0;
                state_d = WAIT_ETX;
              end else begin
                nib_d = nib_q + 4'd1;
              end
            end
          end
          WAIT_ETX: begin
            state_d = WAIT_STX;
            if (rx_byte == ETX && xsum == cs_q) begin
              valid_d  = 1'b1;
              tag_id_d = sh_q;
            end else begin
              err_d = 1'b1;
            end
          end
        endcase
      end
    end else if (timeout) begin
      err_d   = 1'b1;
      state_d = WAIT_STX;
    end
  end

  assign tag_id    = tag_id_q;
  assign tag_valid = valid_q;
  assign tag_err   = err_q;
  assign busy      = (state_q != WAIT_STX);

endmodule

// File: tb/tb_rfid_frame_rx.sv
// Directed bench for rfid_frame_rx with 16 clocks per UART bit.
module tb_rfid_frame_rx;

  localparam int CPB = 16;
  localparam logic [39:0] GOOD_ID = 40'h1A2B3C4D5E;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [39:0] tag_id;
  logic        tag_valid;
  logic        tag_err;
  logic        busy;

  rfid_frame_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .tag_id    (tag_id),
    .tag_valid (tag_valid),
    .tag_err   (tag_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int nvalid = 0;
  int nerr = 0;
  int nboth = 0;
  int valid_cyc = -1;
  int err_cyc = -1;
  int checks = 0;
  int errors = 0;
  int last_start = 0;
  logic [7:0] frm [14];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tag_valid) begin
      nvalid    = nvalid + 1;
      valid_cyc = cyc;
    end
    if (tag_err) begin
      nerr    = nerr + 1;
      err_cyc = cyc;
    end
    if (tag_valid && tag_err) nboth = nboth + 1;
  end

  task automatic load_good();
    frm = '{8'h02, 8'h31, 8'h41, 8'h32, 8'h42, 8'h33, 8'h43,
            8'h34, 8'h44, 8'h35, 8'h45, 8'h31, 8'h45, 8'h03};
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    last_start = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(frm[i], 1'b1);
  endtask

  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * CPB) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (tag_id !== 40'h0) begin
      errors++; $display("FAIL reset_id got %h want %h", tag_id, 40'h0);
    end
    if (tag_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", tag_valid);
    end
    if (tag_err !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b want 0", tag_err);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", busy);
    end
  endtask

  task automatic test_good();
    int v0, e0;
    v0 = nvalid; e0 = nerr;
    load_good();
    send_range(0, 13);
    idle(2);
    checks += 5;
    if (nvalid - v0 !== 1) begin
      errors++; $display("FAIL good_valid_cnt got %0d want 1", nvalid - v0);
    end
    if (nerr - e0 !== 0) begin
      errors++; $display("FAIL good_err_cnt got %0d want 0", nerr - e0);
    end
    if (tag_id !== GOOD_ID) begin
      errors++; $display("FAIL good_id got %h want %h", tag_id, GOOD_ID);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL good_busy got %b want 0", busy);
    end
    if (valid_cyc !== last_start + 155) begin
      errors++; $display("FAIL good_latency got %0d want %0d", valid_cyc, last_start + 155);
    end
  endtask

  task automatic test_bad_csum();
    int v0, e0;
    do_reset();
    v0 = nvalid; e0 = nerr;
    load_good();
    frm[12] = 8'h46;
    send_range(0, 13);
    idle(2);
    checks += 4;
    if (nerr - e0 !== 1) begin
      errors++; $display("FAIL csum_err_cnt got %0d want 1", nerr - e0);
    end
    if (nvalid - v0 !== 0) begin
      errors++; $display("FAIL csum_valid_cnt got %0d want 0", nvalid - v0);
    end
    if (tag_id !== 40'h0) begin
      errors++; $display("FAIL csum_id got %h want %h", tag_id, 40'h0);
    end
    if (err_cyc !== last_start + 155) begin
      errors++; $display("FAIL csum_latency got %0d want %0d", err_cyc, last_start + 155);
    end
    load_good();
  endtask

  task automatic test_bad_char();
    int v0, e0, s;
    v0 = nvalid; e0 = nerr;
    load_good();
    frm[3] = 8'h62;
    send_range(0, 3);
    s = last_start;
    idle(1);
    checks += 3;
    if (nerr - e0 !== 1) begin
      errors++; $display("FAIL char_err_cnt got %0d want 1", nerr - e0);
    end
    if (err_cyc !== s + 155) begin
      errors++; $display("FAIL char_latency got %0d want %0d", err_cyc, s + 155);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL char_busy got %b want 0", busy);
    end
    load_good();
    send_range(0, 13);
    idle(2);
    checks += 2;
    if (nvalid - v0 !== 1) begin
      errors++; $display("FAIL char_next_valid got %0d want 1", nvalid - v0);
    end
    if (tag_id !== GOOD_ID) begin
      errors++; $display("FAIL char_next_id got %h want %h", tag_id, GOOD_ID);
    end
  endtask

  task automatic test_stop_err();
    int v0, e0, s;
    do_reset();
    v0 = nvalid; e0 = nerr;
    load_good();
    send_range(0, 3);
    send_byte(frm[4], 1'b0);
    s = last_start;
    idle(2);
    checks += 3;
    if (nerr - e0 !== 1) begin
      errors++; $display("FAIL stop_err_cnt got %0d want 1", nerr - e0);
    end
    if (err_cyc !== s + 155) begin
      errors++; $display("FAIL stop_latency got %0d want %0d", err_cyc, s + 155);
    end
    if (tag_id !== 40'h0) begin
      errors++; $display("FAIL stop_id_hold got %h want %h", tag_id, 40'h0);
    end
    send_range(0, 13);
    idle(2);
    checks += 2;
    if (nvalid - v0 !== 1) begin
      errors++; $display("FAIL stop_next_valid got %0d want 1", nvalid - v0);
    end
    if (tag_id !== GOOD_ID) begin
      errors++; $display("FAIL stop_next_id got %h want %h", tag_id, GOOD_ID);
    end
  endtask

  task automatic test_timeout();
    int v0, e0, s;
    v0 = nvalid; e0 = nerr;
    load_good();
    send_range(0, 4);
    s = last_start;
    checks += 1;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL to_busy_pre got %b want 1", busy);
    end
    idle(21);
    checks += 4;
    if (nerr - e0 !== 1) begin
      errors++; $display("FAIL to_err_cnt got %0d want 1", nerr - e0);
    end
    if (err_cyc !== s + 154 + 320) begin
      errors++; $display("FAIL to_latency got %0d want %0d", err_cyc, s + 474);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL to_busy_post got %b want 0", busy);
    end
    if (tag_id !== GOOD_ID) begin
      errors++; $display("FAIL to_id_hold got %h want %h", tag_id, GOOD_ID);
    end
    e0 = nerr;
    idle(100);
    checks += 2;
    if (nerr - e0 !== 0) begin
      errors++; $display("FAIL idle_err_cnt got %0d want 0", nerr - e0);
    end
    if (nvalid - v0 !== 0) begin
      errors++; $display("FAIL idle_valid_cnt got %0d want 0", nvalid - v0);
    end
  endtask

  task automatic test_restart();
    int v0, e0, s;
    v0 = nvalid; e0 = nerr;
    load_good();
    send_range(0, 6);
    send_byte(frm[0], 1'b1);
    s = last_start;
    send_range(1, 13);
    idle(2);
    checks += 4;
    if (nerr - e0 !== 1) begin
      errors++; $display("FAIL restart_err_cnt got %0d want 1", nerr - e0);
    end
    if (err_cyc !== s + 155) begin
      errors++; $display("FAIL restart_latency got %0d want %0d", err_cyc, s + 155);
    end
    if (nvalid - v0 !== 1) begin
      errors++; $display("FAIL restart_valid_cnt got %0d want 1", nvalid - v0);
    end
    if (tag_id !== GOOD_ID) begin
      errors++; $display("FAIL restart_id got %h want %h", tag_id, GOOD_ID);
    end
  endtask

  task automatic test_reset_mid();
    int v0, e0;
    load_good();
    send_range(0, 3);
    v0 = nvalid; e0 = nerr;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks += 2;
    if (tag_id !== 40'h0) begin
      errors++; $display("FAIL rstmid_id got %h want %h", tag_id, 40'h0);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_busy got %b want 0", busy);
    end
    idle(3);
    checks += 1;
    if (nerr - e0 !== 0 || nvalid - v0 !== 0) begin
      errors++; $display("FAIL rstmid_strobe got %0d want 0", (nerr - e0) + (nvalid - v0));
    end
    send_range(0, 13);
    idle(2);
    checks += 2;
    if (nvalid - v0 !== 1) begin
      errors++; $display("FAIL rstmid_valid_cnt got %0d want 1", nvalid - v0);
    end
    if (tag_id !== GOOD_ID) begin
      errors++; $display("FAIL rstmid_next_id got %h want %h", tag_id, GOOD_ID);
    end
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = nvalid; e0 = nerr;
    load_good();
    send_range(0, 2);
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    idle(1);
    send_range(3, 13);
    idle(2);
    checks += 2;
    if (nerr - e0 !== 0) begin
      errors++; $display("FAIL glitch_err_cnt got %0d want 0", nerr - e0);
    end
    if (nvalid - v0 !== 1) begin
      errors++; $display("FAIL glitch_valid_cnt got %0d want 1", nvalid - v0);
    end
  endtask

  task automatic test_back_to_back();
    int v0, e0;
    do_reset();
    v0 = nvalid; e0 = nerr;
    load_good();
    send_range(0, 13);
    send_range(0, 13);
    checks += 1;
    if (valid_cyc !== last_start + 155) begin
      errors++; $display("FAIL b2b_latency got %0d want %0d", valid_cyc, last_start + 155);
    end
    idle(2);
    checks += 3;
    if (nvalid - v0 !== 2) begin
      errors++; $display("FAIL b2b_valid_cnt got %0d want 2", nvalid - v0);
    end
    if (nerr - e0 !== 0) begin
      errors++; $display("FAIL b2b_err_cnt got %0d want 0", nerr - e0);
    end
    if (tag_id !== GOOD_ID) begin
      errors++; $display("FAIL b2b_id got %h want %h", tag_id, GOOD_ID);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_good();
    test_bad_csum();
    test_bad_char();
    test_stop_err();
    test_timeout();
    test_restart();
    test_reset_mid();
    test_glitch();
    test_back_to_back();
    checks += 1;
    if (nboth !== 0) begin
      errors++; $display("FAIL valid_err_overlap got %0d want 0", nboth);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
